// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator: free-running coordinate counters, sync decode,
// and a delay line that lines blanking and syncs up with the renderer's RGB.
module svga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 72,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 22,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1,
  parameter int PIPE_DELAY = 1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  output logic [10:0] h_coord,
  output logic [9:0]  v_coord,
  output logic        display_on,
  output logic        frame_start,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        h_wrap;

  always_comb begin
    h_wrap = (h_coord == 11'(H_TOTAL - 1));
    h_next = h_wrap ? 11'd0 : h_coord + 11'd1;
    v_next = v_coord;
    if (h_wrap) v_next = (v_coord == 10'(V_TOTAL - 1)) ? 10'd0 : v_coord + 10'd1;
  end

  // display_on/frame_start come from the next-state values so they line up with the counters
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_coord     <= '0;
      v_coord     <= '0;
      display_on  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_coord     <= h_next;
      v_coord     <= v_next;
      display_on  <= (h_next < 11'(H_ACTIVE)) && (v_next < 10'(V_ACTIVE));
      frame_start <= (h_next == 11'd0) && (v_next == 10'd0);
    end
  end

  logic de_raw, hs_raw, vs_raw;
  assign de_raw = (h_coord < 11'(H_ACTIVE)) && (v_coord < 10'(V_ACTIVE));
  assign hs_raw = (h_coord >= 11'(HS_START)) && (h_coord < 11'(HS_END));
  assign vs_raw = (v_coord >= 10'(VS_START)) && (v_coord < 10'(VS_END));

  logic [2:0] ctl_d;  // {de, hs, vs} delayed to match the renderer latency

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign ctl_d = {de_raw, hs_raw, vs_raw};
    end else begin : g_dly
      logic [2:0] sr [PIPE_DELAY];
      always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= 3'b000;
        end else begin
          sr[0] <= {de_raw, hs_raw, vs_raw};
          for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
        end
      end
      assign ctl_d = sr[PIPE_DELAY-1];
    end
  endgenerate

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~HS_ACT;
      vga_vs <= ~VS_ACT;
    end else begin
      vga_r  <= ctl_d[2] ? red_i   : 4'h0;
      vga_g  <= ctl_d[2] ? green_i : 4'h0;
      vga_b  <= ctl_d[2] ? blue_i  : 4'h0;
      vga_hs <= ctl_d[1] ? HS_ACT : ~HS_ACT;
      vga_vs <= ctl_d[0] ? VS_ACT : ~VS_ACT;
    end
  end

endmodule

// File: tb/tb_svga_timing_gen.sv
// Bench for svga_timing_gen: default geometry plus two shrunken geometries so whole
// frames fit in a short run; outputs are predicted from the cycle count since release.
module tb_svga_timing_gen;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [10:0] h_c [NI];
  logic [9:0]  v_c [NI];
  logic        don [NI];
  logic        fs  [NI];
  logic [3:0]  ri [NI], gi [NI], bi [NI];
  logic [3:0]  vr [NI], vg [NI], vb [NI];
  logic        hs [NI], vs [NI];

  svga_timing_gen #(.PIPE_DELAY(1)) u0 (
    .pixel_clk(clk), .rst_n(rst_n), .h_coord(h_c[0]), .v_coord(v_c[0]),
    .display_on(don[0]), .frame_start(fs[0]), .red_i(ri[0]), .green_i(gi[0]),
    .blue_i(bi[0]), .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]));

  svga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                    .HS_POL(1), .VS_POL(1), .PIPE_DELAY(0)) u1 (
    .pixel_clk(clk), .rst_n(rst_n), .h_coord(h_c[1]), .v_coord(v_c[1]),
    .display_on(don[1]), .frame_start(fs[1]), .red_i(ri[1]), .green_i(gi[1]),
    .blue_i(bi[1]), .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]));

  svga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                    .HS_POL(0), .VS_POL(0), .PIPE_DELAY(3)) u2 (
    .pixel_clk(clk), .rst_n(rst_n), .h_coord(h_c[2]), .v_coord(v_c[2]),
    .display_on(don[2]), .frame_start(fs[2]), .red_i(ri[2]), .green_i(gi[2]),
    .blue_i(bi[2]), .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2]),
    .vga_hs(hs[2]), .vga_vs(vs[2]));

  // fields: HA HFP HS HBP VA VFP VS VBP HPOL VPOL PD
  function automatic int cfg(int i, int k);
    int t [11];
    case (i)
      0:       t = '{800, 24, 72, 128, 600, 1, 2, 22, 1, 1, 1};
      1:       t = '{16, 2, 4, 3, 6, 1, 2, 2, 1, 1, 0};
      default: t = '{16, 2, 4, 3, 6, 1, 2, 2, 0, 0, 3};
    endcase
    return t[k];
  endfunction

  function automatic int htot(int i);
    return cfg(i,0) + cfg(i,1) + cfg(i,2) + cfg(i,3);
  endfunction

  function automatic int vtot(int i);
    return cfg(i,4) + cfg(i,5) + cfg(i,6) + cfg(i,7);
  endfunction

  int n;
  int checks = 0;
  int fails  = 0;
  logic [11:0] hist [NI][8192];
  int last_fs [NI];

  task automatic chk(string name, int inst, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s inst=%0d cycle=%0d got=%0d expected=%0d", name, inst, n, got, exp);
    end
  endtask

  task automatic check_cycle(int i);
    int ht, vt, hh, vv, m, hm, vm, pd, exp_rgb;
    bit hsa, vsa, de;
    ht = htot(i);
    vt = vtot(i);
    pd = cfg(i,10);
    hh = n % ht;
    vv = (n / ht) % vt;
    chk("h_coord", i, h_c[i], hh);
    chk("v_coord", i, v_c[i], vv);
    chk("display_on", i, don[i], (n > 0 && hh < cfg(i,0) && vv < cfg(i,4)) ? 1 : 0);
    chk("frame_start", i, fs[i], (n > 0 && hh == 0 && vv == 0) ? 1 : 0);
    m = n - pd - 1;
    exp_rgb = 0;
    hsa = 1'b0;
    vsa = 1'b0;
    if (m >= 0) begin
      hm  = m % ht;
      vm  = (m / ht) % vt;
      de  = (hm < cfg(i,0)) && (vm < cfg(i,4));
      hsa = (hm >= cfg(i,0) + cfg(i,1)) && (hm < cfg(i,0) + cfg(i,1) + cfg(i,2));
      vsa = (vm >= cfg(i,4) + cfg(i,5)) && (vm < cfg(i,4) + cfg(i,5) + cfg(i,6));
      if (de) exp_rgb = int'(hist[i][m + pd]);
    end
    chk("vga_rgb", i, {vr[i], vg[i], vb[i]}, exp_rgb);
    chk("vga_hs", i, hs[i], (hsa ? cfg(i,8) : 1 - cfg(i,8)));
    chk("vga_vs", i, vs[i], (vsa ? cfg(i,9) : 1 - cfg(i,9)));
    if (vv >= cfg(i,4)) chk("vblank_rgb", i, {vr[i], vg[i], vb[i]}, 0);
  endtask

  task automatic drive(int i);
    int ht, pd, vv;
    logic [11:0] c;
    ht = htot(i);
    pd = cfg(i,10);
    vv = (n / ht) % vtot(i);
    c = 12'($urandom_range(0, 4095));
    if (i == 0 && n >= pd) c[11:8] = 4'((n - pd) % ht);  // red = h_coord[3:0] delayed by PD
    if (vv >= cfg(i,4)) c = 12'hFFF;
    hist[i][n] = c;
    ri[i] = c[11:8];
    gi[i] = c[7:4];
    bi[i] = c[3:0];
  endtask

  task automatic check_reset();
    for (int i = 0; i < NI; i++) begin
      chk("rst_h", i, h_c[i], 0);
      chk("rst_v", i, v_c[i], 0);
      chk("rst_display_on", i, don[i], 0);
      chk("rst_frame_start", i, fs[i], 0);
      chk("rst_rgb", i, {vr[i], vg[i], vb[i]}, 0);
      chk("rst_hs", i, hs[i], 1 - cfg(i,8));
      chk("rst_vs", i, vs[i], 1 - cfg(i,9));
    end
  endtask

  typedef struct {
    int n;
    int h;
    int v;
    bit don;
    bit fs;
    bit hs;
  } vec_t;
  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic run_phase(int cycles);
    for (int i = 0; i < NI; i++) last_fs[i] = -1;
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n = k;
      for (int i = 0; i < NI; i++) check_cycle(i);
      for (int j = 0; j < NV; j++) begin
        if (tbl[j].n == n) begin
          chk("tbl_h", 0, h_c[0], tbl[j].h);
          chk("tbl_v", 0, v_c[0], tbl[j].v);
          chk("tbl_display_on", 0, don[0], tbl[j].don);
          chk("tbl_frame_start", 0, fs[0], tbl[j].fs);
          chk("tbl_vga_hs", 0, hs[0], tbl[j].hs);
        end
      end
      for (int i = 1; i < NI; i++) begin
        if (fs[i] === 1'b1) begin
          if (last_fs[i] >= 0) chk("frame_period", i, n - last_fs[i], htot(i) * vtot(i));
          last_fs[i] = n;
        end
      end
      for (int i = 0; i < NI; i++) drive(i);
    end
  endtask

  initial begin
    tbl[0]  = '{0,    0,    0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1,    1,    0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{799,  799,  0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{800,  800,  0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{825,  825,  0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{826,  826,  0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{897,  897,  0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{898,  898,  0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1023, 1023, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1024, 0,    1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1850, 826,  1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1921, 897,  1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1922, 898,  1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    n = 0;
    for (int i = 0; i < NI; i++) begin
      ri[i] = 4'h0;
      gi[i] = 4'h0;
      bi[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    run_phase(2813);

    // asynchronous reset mid-frame, between clock edges
    #3 rst_n = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    run_phase(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
